// File: rtl/bp_fe_lce_resp_merge.sv
// bp_fe_lce_resp_merge
// Merges the FE request-side and command-side LCE response streams into one
// registered stream toward the CCE response network. A small FIFO cuts the
// network ready path away from both sources. Arbitration favours the request
// side, but the command side is forced through after a bounded streak.
module bp_fe_lce_resp_merge #(
  parameter int resp_width_p = 64,
  parameter int fifo_els_p   = 2,
  parameter int max_streak_p = 3
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,

  input  logic [resp_width_p-1:0]         req_resp_i,
  input  logic                            req_resp_v_i,
  output logic                            req_resp_yumi_o,

  input  logic [resp_width_p-1:0]         cmd_resp_i,
  input  logic                            cmd_resp_v_i,
  output logic                            cmd_resp_yumi_o,

  output logic [resp_width_p-1:0]         lce_resp_o,
  output logic                            lce_resp_v_o,
  input  logic                            lce_resp_ready_i,

  output logic [$clog2(fifo_els_p):0]     occupancy_o,
  output logic                            idle_o
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;
  localparam logic [cnt_w_lp-1:0] full_cnt_lp   = cnt_w_lp'(fifo_els_p);
  localparam logic [1:0]          max_streak_lp = 2'(max_streak_p);

  logic [resp_width_p-1:0] r_mem [fifo_els_p];
  logic [ptr_w_lp-1:0]     r_rd_ptr;
  logic [ptr_w_lp-1:0]     r_wr_ptr;
  logic [cnt_w_lp-1:0]     r_count;
  logic [1:0]              r_streak;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_grant_req;
  logic                    w_grant_cmd;
  logic                    w_enq;
  logic                    w_deq;
  logic [resp_width_p-1:0] w_enq_data;

  assign w_full  = (r_count == full_cnt_lp);
  assign w_empty = (r_count == '0);

  // Grant selection: one source per cycle, only into a non-full FIFO; the
  // command side wins a contended cycle once the request streak saturates.
  // Grants are gated by reset so the sources never see a yumi during reset.
  always_comb begin
    w_grant_req = 1'b0;
    w_grant_cmd = 1'b0;
    if (reset_n_i && !w_full) begin
      if (cmd_resp_v_i && (!req_resp_v_i || (r_streak == max_streak_lp))) begin
        w_grant_cmd = 1'b1;
      end else if (req_resp_v_i) begin
        w_grant_req = 1'b1;
      end
    end
  end

  assign req_resp_yumi_o = w_grant_req;
  assign cmd_resp_yumi_o = w_grant_cmd;

  assign w_enq      = w_grant_req | w_grant_cmd;
  assign w_enq_data = w_grant_cmd ? cmd_resp_i : req_resp_i;
  assign w_deq      = !w_empty && lce_resp_ready_i;

  assign lce_resp_o   = r_mem[r_rd_ptr];
  assign lce_resp_v_o = !w_empty;
  assign occupancy_o  = r_count;
  assign idle_o       = w_empty && !req_resp_v_i && !cmd_resp_v_i;

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= w_enq_data;
    end
  end

  // FIFO pointers and entry count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + ptr_w_lp'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + ptr_w_lp'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + cnt_w_lp'(1);
        2'b01:   r_count <= r_count - cnt_w_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Streak of request grants won against a waiting command packet; held while full.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_streak <= '0;
    end else if (!w_full) begin
      if (!cmd_resp_v_i || w_grant_cmd) begin
        r_streak <= '0;
      end else if (w_grant_req && (r_streak != max_streak_lp)) begin
        r_streak <= r_streak + 2'd1;
      end
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    r_count <= full_cnt_lp);
  a_req_yumi_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    req_resp_yumi_o |-> req_resp_v_i);
  a_cmd_yumi_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    cmd_resp_yumi_o |-> cmd_resp_v_i);
  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(req_resp_yumi_o && cmd_resp_yumi_o));

endmodule

// File: tb/tb_bp_fe_lce_resp_merge.sv
// Testbench for bp_fe_lce_resp_merge: a table of per-cycle vectors covers the
// single-source, backpressure, starvation and streak-clear cases; hand-written
// sequences cover FIFO wrap under toggling ready and asynchronous reset.
module tb_bp_fe_lce_resp_merge;

  localparam int W = 64;

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  reqResp;
  logic          reqV;
  logic          reqYumi;
  logic [W-1:0]  cmdResp;
  logic          cmdV;
  logic          cmdYumi;
  logic [W-1:0]  lceResp;
  logic          lceV;
  logic          lceReady;
  logic [1:0]    occupancy;
  logic          idle;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rv;
    logic [7:0] rd;
    logic       cv;
    logic [7:0] cd;
    logic       rdy;
    logic       eRy;
    logic       eCy;
    logic       eV;
    logic [7:0] eD;
    logic [1:0] eOcc;
    logic       eIdle;
  } vec_t;

  vec_t vecs[$];

  bp_fe_lce_resp_merge #(
    .resp_width_p(W),
    .fifo_els_p  (2),
    .max_streak_p(3)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .req_resp_i      (reqResp),
    .req_resp_v_i    (reqV),
    .req_resp_yumi_o (reqYumi),
    .cmd_resp_i      (cmdResp),
    .cmd_resp_v_i    (cmdV),
    .cmd_resp_yumi_o (cmdYumi),
    .lce_resp_o      (lceResp),
    .lce_resp_v_o    (lceV),
    .lce_resp_ready_i(lceReady),
    .occupancy_o     (occupancy),
    .idle_o          (idle)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and logs a miss.
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Appends one cycle of stimulus plus expected outputs to the vector table.
  function automatic void add(logic rv, logic [7:0] rd, logic cv, logic [7:0] cd, logic rdy,
                              logic eRy, logic eCy, logic eV, logic [7:0] eD,
                              logic [1:0] eOcc, logic eIdle);
    vec_t v;
    v.rv = rv; v.rd = rd; v.cv = cv; v.cd = cd; v.rdy = rdy;
    v.eRy = eRy; v.eCy = eCy; v.eV = eV; v.eD = eD; v.eOcc = eOcc; v.eIdle = eIdle;
    vecs.push_back(v);
  endfunction

  // Drives one vector at the falling edge and checks outputs before the rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    reqV     = v.rv;
    reqResp  = W'(v.rd);
    cmdV     = v.cv;
    cmdResp  = W'(v.cd);
    lceReady = v.rdy;
    #1;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, ".req_yumi"}, W'(reqYumi), W'(v.eRy));
    checkOutput({tag, ".cmd_yumi"}, W'(cmdYumi), W'(v.eCy));
    checkOutput({tag, ".v"},        W'(lceV),    W'(v.eV));
    if (v.eV) checkOutput({tag, ".data"}, lceResp, W'(v.eD));
    checkOutput({tag, ".occ"},      W'(occupancy), W'(v.eOcc));
    checkOutput({tag, ".idle"},     W'(idle),    W'(v.eIdle));
  endtask

  initial begin
    int sent;
    int recv;
    int occOver;

    reset_n  = 1'b0;
    reqV     = 1'b1;
    reqResp  = W'(8'hEE);
    cmdV     = 1'b1;
    cmdResp  = W'(8'hEF);
    lceReady = 1'b1;

    // Reset held for three cycles with both sources valid.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst.req_yumi", W'(reqYumi), '0);
      checkOutput("rst.cmd_yumi", W'(cmdYumi), '0);
      checkOutput("rst.v",        W'(lceV),    '0);
      checkOutput("rst.occ",      W'(occupancy), '0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    reqV    = 1'b0;
    cmdV    = 1'b0;

    //     rv rd     cv cd     rdy  eRy eCy eV eD     occ idle
    // Single source after reset.
    add(1, 8'hA1, 0, 8'h00, 1,   1,  0,  0, 8'h00, 0,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  1, 8'hA1, 1,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  0, 8'h00, 0,  1);
    // Backpressure until full, then drain.
    add(1, 8'h10, 0, 8'h00, 0,   1,  0,  0, 8'h00, 0,  0);
    add(1, 8'h11, 0, 8'h00, 0,   1,  0,  1, 8'h10, 1,  0);
    add(1, 8'h12, 0, 8'h00, 0,   0,  0,  1, 8'h10, 2,  0);
    add(1, 8'h12, 0, 8'h00, 0,   0,  0,  1, 8'h10, 2,  0);
    add(1, 8'h12, 0, 8'h00, 1,   0,  0,  1, 8'h10, 2,  0);
    add(1, 8'h12, 0, 8'h00, 1,   1,  0,  1, 8'h11, 1,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  1, 8'h12, 1,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  0, 8'h00, 0,  1);
    // Starvation bound: three request grants, then the command packet.
    add(1, 8'h20, 1, 8'hC0, 1,   1,  0,  0, 8'h00, 0,  0);
    add(1, 8'h21, 1, 8'hC0, 1,   1,  0,  1, 8'h20, 1,  0);
    add(1, 8'h22, 1, 8'hC0, 1,   1,  0,  1, 8'h21, 1,  0);
    add(1, 8'h23, 1, 8'hC0, 1,   0,  1,  1, 8'h22, 1,  0);
    add(1, 8'h23, 0, 8'h00, 1,   1,  0,  1, 8'hC0, 1,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  1, 8'h23, 1,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  0, 8'h00, 0,  1);
    // Streak clear: command drops after two contended cycles, then returns.
    add(1, 8'h40, 1, 8'hD0, 1,   1,  0,  0, 8'h00, 0,  0);
    add(1, 8'h41, 1, 8'hD0, 1,   1,  0,  1, 8'h40, 1,  0);
    add(1, 8'h42, 0, 8'h00, 1,   1,  0,  1, 8'h41, 1,  0);
    add(1, 8'h43, 1, 8'hD0, 1,   1,  0,  1, 8'h42, 1,  0);
    add(1, 8'h44, 1, 8'hD0, 1,   1,  0,  1, 8'h43, 1,  0);
    add(1, 8'h45, 1, 8'hD0, 1,   1,  0,  1, 8'h44, 1,  0);
    add(1, 8'h46, 1, 8'hD0, 1,   0,  1,  1, 8'h45, 1,  0);
    add(1, 8'h46, 0, 8'h00, 1,   1,  0,  1, 8'hD0, 1,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  1, 8'h46, 1,  0);
    add(0, 8'h00, 0, 8'h00, 1,   0,  0,  0, 8'h00, 0,  1);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Wrap: eight request packets streamed with ready toggling every cycle.
    sent    = 0;
    recv    = 0;
    occOver = 0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(negedge clk);
      reqV     = (sent < 8);
      reqResp  = W'(8'h30 + sent);
      cmdV     = 1'b0;
      lceReady = (cyc % 2 == 0);
      #1;
      if (occupancy > 2'd2) occOver++;
      if (lceV && lceReady) begin
        checkOutput($sformatf("wrap.data%0d", recv), lceResp, W'(8'h30 + recv));
        recv++;
      end
      if (reqYumi) sent++;
    end
    checkOutput("wrap.received", W'(recv), W'(8));
    checkOutput("wrap.occ_over", W'(occOver), '0);
    @(negedge clk);
    reqV = 1'b0;
    #1;
    checkOutput("wrap.drained", W'(lceV), '0);

    // Asynchronous reset with two entries buffered.
    lceReady = 1'b0;
    @(negedge clk);
    reqV    = 1'b1;
    reqResp = W'(8'h50);
    @(negedge clk);
    reqResp = W'(8'h51);
    @(negedge clk);
    reqResp = W'(8'h52);
    cmdV    = 1'b1;
    cmdResp = W'(8'hC5);
    #1;
    checkOutput("arst.pre_occ", W'(occupancy), W'(2));
    @(posedge clk);
    #2;
    checkOutput("arst.pre_v", W'(lceV), W'(1));
    reset_n = 1'b0;
    #1;
    checkOutput("arst.v",        W'(lceV),      '0);
    checkOutput("arst.occ",      W'(occupancy), '0);
    checkOutput("arst.req_yumi", W'(reqYumi),   '0);
    checkOutput("arst.cmd_yumi", W'(cmdYumi),   '0);
    @(posedge clk);
    #1;
    checkOutput("arst.hold_v",        W'(lceV),    '0);
    checkOutput("arst.hold_req_yumi", W'(reqYumi), '0);
    @(negedge clk);
    reset_n = 1'b1;
    reqV    = 1'b0;
    cmdV    = 1'b0;
    #1;
    checkOutput("arst.after_idle", W'(idle), W'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
